// File: rtl/pmem_rr_scheduler.sv
// Arbitrates one shared physical-memory line port among NUM_REQ requesters.
// High-priority peers rotate round-robin; the last requester wins only when idle or starved.
module pmem_rr_scheduler #(
  parameter int NUM_REQ      = 3,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*32-1:0]      req_address,
  input  logic [NUM_REQ*LINE_W-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]         req_read,
  input  logic [NUM_REQ-1:0]         req_write,
  output logic [LINE_W-1:0]          req_rdata,
  output logic [NUM_REQ-1:0]         req_resp,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [31:0]                c_pmem_address,
  output logic [LINE_W-1:0]          c_pmem_wdata,
  output logic                       c_pmem_read,
  output logic                       c_pmem_write,
  input  logic [LINE_W-1:0]          c_pmem_rdata,
  input  logic                       c_pmem_resp
);

  localparam int GW     = $clog2(NUM_REQ);
  localparam int NUM_HI = NUM_REQ - 1;
  localparam int LP     = NUM_REQ - 1;
  localparam int SW     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  resp_q, resp_d;
  logic [GW-1:0]       grant_q, grant_d;

  logic [NUM_REQ-1:0]  pending;
  logic [31:0]         addr_arr  [NUM_REQ];
  logic [LINE_W-1:0]   wdata_arr [NUM_REQ];
  logic                win_valid;
  logic                win_lp;
  logic [GW-1:0]       win_idx;

  assign pending = req_read | req_write;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign addr_arr[gi]  = req_address[gi*32 +: 32];
    assign wdata_arr[gi] = req_wdata[gi*LINE_W +: LINE_W];
  end

  // Round-robin scan is done in two passes: indices at/after rr_q first, then the wrap.
  always_comb begin
    win_valid = 1'b0;
    win_lp    = 1'b0;
    win_idx   = '0;
    if (pending[LP] && (starve_q == SW'(STARVE_LIMIT))) begin
      win_valid = 1'b1;
      win_lp    = 1'b1;
      win_idx   = GW'(LP);
    end else begin
      for (int j = 0; j < NUM_HI; j++) begin
        if (!win_valid && pending[j] && (j >= int'(rr_q))) begin
          win_valid = 1'b1;
          win_idx   = GW'(j);
        end
      end
      for (int j = 0; j < NUM_HI; j++) begin
        if (!win_valid && pending[j]) begin
          win_valid = 1'b1;
          win_idx   = GW'(j);
        end
      end
      if (!win_valid && pending[LP]) begin
        win_valid = 1'b1;
        win_lp    = 1'b1;
        win_idx   = GW'(LP);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    resp_d   = '0;
    grant_d  = grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (!pending[LP]) begin
          starve_d = '0;
        end
        if (win_valid) begin
          addr_d  = addr_arr[win_idx];
          wdata_d = wdata_arr[win_idx];
          // A simultaneous read+write is serviced as a write.
          write_d = req_write[win_idx];
          read_d  = req_read[win_idx] & ~req_write[win_idx];
          grant_d = win_idx;
          state_d = S_BUSY;
          if (win_lp) begin
            starve_d = '0;
          end else begin
            rr_d = (win_idx == GW'(NUM_HI - 1)) ? '0 : win_idx + GW'(1);
            if (pending[LP] && (starve_q != SW'(STARVE_LIMIT))) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end
      S_BUSY: begin
        if (c_pmem_resp) begin
          if (read_q) begin
            rdata_d = c_pmem_rdata;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          resp_d  = NUM_REQ'(1) << grant_q;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      resp_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      grant_q  <= grant_d;
    end
  end

  assign req_rdata      = rdata_q;
  assign req_resp       = resp_q;
  assign grant_id       = grant_q;
  assign c_pmem_address = addr_q;
  assign c_pmem_wdata   = wdata_q;
  assign c_pmem_read    = read_q;
  assign c_pmem_write   = write_q;

endmodule

// File: tb/tb_pmem_rr_scheduler.sv
// Directed bench for pmem_rr_scheduler: a latency-programmable memory responder plus
// scenario tasks with hand-computed expectations.
module tb_pmem_rr_scheduler;

  localparam int NUM_REQ      = 3;
  localparam int LINE_W       = 256;
  localparam int STARVE_LIMIT = 8;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ*32-1:0]     req_address;
  logic [NUM_REQ*LINE_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [LINE_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        req_resp;
  logic [1:0]                grant_id;
  logic [31:0]               c_pmem_address;
  logic [LINE_W-1:0]         c_pmem_wdata;
  logic                      c_pmem_read;
  logic                      c_pmem_write;
  logic [LINE_W-1:0]         c_pmem_rdata;
  logic                      c_pmem_resp;

  logic mem_resp;
  logic force_resp;
  logic mem_en;
  int   mem_lat;
  int   mem_cnt;
  int   errors;
  int   checks;
  int   violations;

  assign c_pmem_resp = mem_resp | force_resp;

  pmem_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_address(req_address), .req_wdata(req_wdata),
    .req_read(req_read), .req_write(req_write),
    .req_rdata(req_rdata), .req_resp(req_resp), .grant_id(grant_id),
    .c_pmem_address(c_pmem_address), .c_pmem_wdata(c_pmem_wdata),
    .c_pmem_read(c_pmem_read), .c_pmem_write(c_pmem_write),
    .c_pmem_rdata(c_pmem_rdata), .c_pmem_resp(c_pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int j = 0; j < LINE_W/32; j++) l[j*32 +: 32] = a ^ 32'hA5A5_A5A5 ^ 32'(j);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] pattern(input logic [31:0] seed);
    logic [LINE_W-1:0] l;
    for (int j = 0; j < LINE_W/32; j++) l[j*32 +: 32] = seed + 32'(j * 32'h0101_0101);
    return l;
  endfunction

  // Memory: answers each strobe after mem_lat cycles with a one-cycle resp pulse.
  initial begin
    mem_resp = 1'b0;
    mem_cnt = 0;
    c_pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst || !mem_en || mem_resp) begin
        mem_resp = 1'b0;
        mem_cnt = 0;
      end else if (c_pmem_read || c_pmem_write) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_resp = 1'b1;
          c_pmem_rdata = mem_line(c_pmem_address);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [LINE_W-1:0] d,
                         input logic rd, input logic wr);
    req_address[i*32 +: 32]       = a;
    req_wdata[i*LINE_W +: LINE_W] = d;
    req_read[i]                   = rd;
    req_write[i]                  = wr;
    if (rd && wr) begin
      violations++;
      $display("note: requester %0d drives read and write together (protocol violation)", i);
    end
  endtask

  task automatic drop_all();
    req_read  = '0;
    req_write = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drop_all();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_resp(input int max_cyc, output logic [NUM_REQ-1:0] r, output int cyc);
    r = '0;
    cyc = 0;
    while (r == '0 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      r = req_resp;
    end
    checks++;
    if (r == '0) begin
      errors++;
      $display("FAIL resp_timeout: got no req_resp within %0d cycles, required a pulse", max_cyc);
    end else begin
      $display("txn: resp=%b grant_id=%0d rdata=%h", r, grant_id, req_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drop_all();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_resp, grant_id, c_pmem_read, c_pmem_write} !== '0 || c_pmem_address !== '0 ||
        c_pmem_wdata !== '0 || req_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got resp=%b gid=%0d rd=%b wr=%b addr=%h, required all zero",
               req_resp, grant_id, c_pmem_read, c_pmem_write, c_pmem_address);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_resp, c_pmem_read, c_pmem_write} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got resp=%b rd=%b wr=%b, required zero with no requests",
               req_resp, c_pmem_read, c_pmem_write);
    end
  endtask

  task automatic test_single_read();
    logic [NUM_REQ-1:0] r;
    int cyc;
    do_reset();
    mem_lat = 5;
    set_req(0, 32'h0000_1000, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (c_pmem_read !== 1'b1 || c_pmem_write !== 1'b0 || c_pmem_address !== 32'h0000_1000) begin
      errors++;
      $display("FAIL read_issue: got rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=00001000",
               c_pmem_read, c_pmem_write, c_pmem_address);
    end
    wait_resp(20, r, cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL read_latency: got resp after %0d more cycles, required 5", cyc);
    end
    checks++;
    if (r !== 3'b001 || req_rdata !== mem_line(32'h0000_1000) || c_pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: got resp=%b rd=%b rdata=%h, required resp=001 rd=0 rdata=%h",
               r, c_pmem_read, req_rdata, mem_line(32'h0000_1000));
    end
    drop_all();
    @(negedge clk);
    checks++;
    if (req_resp !== 3'b000) begin
      errors++;
      $display("FAIL resp_width: got resp=%b one cycle later, required 000", req_resp);
    end
  endtask

  task automatic test_alternate();
    logic [NUM_REQ-1:0] r;
    int cyc;
    logic [NUM_REQ-1:0] exp;
    do_reset();
    mem_lat = 2;
    set_req(0, 32'h0000_0100, '0, 1'b1, 1'b0);
    set_req(1, 32'h0000_0200, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_resp(20, r, cyc);
      exp = (k % 2 == 0) ? 3'b001 : 3'b010;
      checks++;
      if (r !== exp || grant_id !== 2'(k % 2) ||
          req_rdata !== mem_line((k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200)) begin
        errors++;
        $display("FAIL alternate_%0d: got resp=%b gid=%0d, required resp=%b gid=%0d",
                 k, r, grant_id, exp, k % 2);
      end
    end
    drop_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [NUM_REQ-1:0] r;
    int cyc;
    logic [NUM_REQ-1:0] exp;
    do_reset();
    mem_lat = 1;
    set_req(0, 32'h0000_0100, '0, 1'b1, 1'b0);
    set_req(1, 32'h0000_0200, '0, 1'b1, 1'b0);
    set_req(2, 32'h0000_0300, '0, 1'b1, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      wait_resp(20, r, cyc);
      if (k == 9 || k == 18)  exp = 3'b100;
      else if (k < 9)         exp = ((k - 1) % 2 == 0) ? 3'b001 : 3'b010;
      else                    exp = ((k - 10) % 2 == 0) ? 3'b001 : 3'b010;
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL starve_grant_%0d: got resp=%b, required %b", k, r, exp);
      end
    end
    drop_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_hold();
    logic [NUM_REQ-1:0] r;
    int cyc;
    logic [LINE_W-1:0] p;
    do_reset();
    mem_lat = 2;
    set_req(0, 32'h0000_1000, '0, 1'b1, 1'b0);
    wait_resp(20, r, cyc);
    drop_all();
    @(negedge clk);
    p = pattern(32'h1234_5678);
    mem_lat = 4;
    set_req(1, 32'h0000_2040, p, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (c_pmem_write !== 1'b1 || c_pmem_read !== 1'b0 || c_pmem_address !== 32'h0000_2040 ||
        c_pmem_wdata !== p || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL write_issue: got wr=%b rd=%b addr=%h gid=%0d, required wr=1 rd=0 addr=00002040 gid=1",
               c_pmem_write, c_pmem_read, c_pmem_address, grant_id);
    end
    set_req(1, 32'h9999_0000, ~p, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (c_pmem_wdata !== p || c_pmem_address !== 32'h0000_2040) begin
      errors++;
      $display("FAIL write_hold: got addr=%h wdata=%h, required addr=00002040 wdata=%h",
               c_pmem_address, c_pmem_wdata, p);
    end
    wait_resp(20, r, cyc);
    checks++;
    if (r !== 3'b010 || req_rdata !== mem_line(32'h0000_1000) || c_pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: got resp=%b wr=%b rdata=%h, required resp=010 wr=0 rdata=%h",
               r, c_pmem_write, req_rdata, mem_line(32'h0000_1000));
    end
    drop_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_write_both();
    logic [NUM_REQ-1:0] r;
    int cyc;
    int extra;
    logic [LINE_W-1:0] q;
    do_reset();
    mem_lat = 2;
    q = pattern(32'hCAFE_0000);
    set_req(0, 32'h0000_3000, q, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (c_pmem_write !== 1'b1 || c_pmem_read !== 1'b0 || c_pmem_wdata !== q) begin
      errors++;
      $display("FAIL both_is_write: got wr=%b rd=%b, required wr=1 rd=0", c_pmem_write, c_pmem_read);
    end
    wait_resp(20, r, cyc);
    checks++;
    if (r !== 3'b001 || req_rdata !== '0) begin
      errors++;
      $display("FAIL both_resp: got resp=%b rdata=%h, required resp=001 rdata=0", r, req_rdata);
    end
    drop_all();
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (req_resp != '0 || c_pmem_read || c_pmem_write) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL both_single_txn: got %0d cycles of extra activity, required 0", extra);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [NUM_REQ-1:0] r;
    int cyc;
    int extra;
    do_reset();
    mem_lat = 2;
    set_req(1, 32'h0000_4000, '0, 1'b1, 1'b0);
    wait_resp(20, r, cyc);
    drop_all();
    @(negedge clk);
    mem_lat = 10;
    set_req(1, 32'h0000_5000, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (c_pmem_read !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL busy_before_reset: got rd=%b gid=%0d, required rd=1 gid=1", c_pmem_read, grant_id);
    end
    mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({req_resp, grant_id, c_pmem_read, c_pmem_write} !== '0 || c_pmem_address !== '0 ||
        req_rdata !== '0) begin
      errors++;
      $display("FAIL async_reset: got resp=%b gid=%0d rd=%b addr=%h, required all zero",
               req_resp, grant_id, c_pmem_read, c_pmem_address);
    end
    drop_all();
    @(negedge clk);
    rst = 1'b1;
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (req_resp != '0 || c_pmem_read || c_pmem_write || req_rdata != '0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL late_resp_ignored: got %0d cycles of activity, required 0", extra);
    end
    mem_en = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    violations = 0;
    mem_en = 1'b1;
    mem_lat = 2;
    force_resp = 1'b0;
    req_address = '0;
    req_wdata = '0;
    req_read = '0;
    req_write = '0;
    rst = 1'b0;
    test_reset();
    test_single_read();
    test_alternate();
    test_starvation();
    test_write_hold();
    test_read_write_both();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
